// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - state encoding and ASCII constants shared by the UART TX arbiter
package uart_tx_arbiter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_TAG0  = 3'd1;
  localparam state_t ST_TAG1  = 3'd2;
  localparam state_t ST_FETCH = 3'd3;
  localparam state_t ST_SEND  = 3'd4;

  localparam logic [7:0] TAG_SEP    = 8'h3A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rtl/uart_tx_arbiter_rr.sv - combinational round-robin picker: first requester at/after base
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      base,
  output logic [NUM_SRC-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic [IW-1:0] probe;

  // Scan from the far end back towards base so the nearest requester wins last.
  always_comb begin
    idx   = '0;
    probe = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      probe = IW'((int'(base) + k) % NUM_SRC);
      if (req[probe]) idx = probe;
    end
  end

  assign valid = |req;
  assign grant = valid ? (NUM_SRC'(1) << idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin sharing of one UART TX between byte sources
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int IDLE_TIMEOUT = 65535,
  parameter int TAG_EN       = 1
) (
  input  logic                       clk125,
  input  logic                       reset_n,
  input  logic [8*NUM_SRC-1:0]       s_tdata,
  input  logic [NUM_SRC-1:0]         s_tvalid,
  input  logic [NUM_SRC-1:0]         s_tlast,
  output logic [NUM_SRC-1:0]         s_tready,
  output logic [7:0]                 m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic [15:0]                timeout_cnt
);

  localparam int IW = $clog2(NUM_SRC);

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr, rr_nxt, arb_idx;
  logic [NUM_SRC-1:0] arb_grant, grant_oh;
  logic               arb_valid;
  logic [15:0]        idle_cnt;
  logic               idle_hit, accept, cap_last;
  logic [7:0]         sel_data;
  logic               sel_valid, sel_last;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .IW(IW)) u_rr (
    .req   (s_tvalid),
    .base  (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_oh[i]) sel_data = s_tdata[8*i +: 8];
    end
  end

  assign sel_valid = |(grant_oh & s_tvalid);
  assign sel_last  = |(grant_oh & s_tlast);
  assign accept    = m_tready && m_tvalid;
  assign idle_hit  = (idle_cnt == 16'(IDLE_TIMEOUT - 1));
  assign rr_nxt    = (grant_id == IW'(NUM_SRC - 1)) ? '0 : grant_id + IW'(1);

  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (arb_valid) state_nxt = (TAG_EN != 0) ? ST_TAG0 : ST_FETCH;
      ST_TAG0:  if (accept) state_nxt = ST_TAG1;
      ST_TAG1:  if (accept) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (sel_valid)     state_nxt = ST_SEND;
        else if (idle_hit) state_nxt = ST_IDLE;
      end
      ST_SEND:  if (accept) state_nxt = cap_last ? ST_IDLE : ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    if (state == ST_FETCH) s_tready = grant_oh & s_tvalid;
  end

  // Tag bytes are loaded straight from the IDLE decision so the tag is presented on grant.
  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      grant_oh    <= '0;
      busy        <= 1'b0;
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      cap_last    <= 1'b0;
      idle_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_id <= arb_idx;
            grant_oh <= arb_grant;
            busy     <= 1'b1;
            idle_cnt <= '0;
            if (TAG_EN != 0) begin
              m_tdata  <= ASCII_ZERO + 8'(arb_idx);
              m_tvalid <= 1'b1;
            end
          end
        end
        ST_TAG0: if (accept) m_tdata <= TAG_SEP;
        ST_TAG1: if (accept) m_tvalid <= 1'b0;
        ST_FETCH: begin
          if (sel_valid) begin
            m_tdata  <= sel_data;
            m_tvalid <= 1'b1;
            cap_last <= sel_last;
            idle_cnt <= '0;
          end else if (idle_hit) begin
            busy     <= 1'b0;
            rr_ptr   <= rr_nxt;
            idle_cnt <= '0;
            if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        ST_SEND: begin
          if (accept) begin
            m_tvalid <= 1'b0;
            if (cap_last) begin
              busy   <= 1'b0;
              rr_ptr <= rr_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a message-level round-robin model
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  typedef struct packed {logic [7:0] d; logic last; logic [7:0] gap;} ent_t;
  typedef struct packed {logic [7:0] d; logic [1:0] g; logic lastb;} exp_t;

  logic clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  logic             reset_n;
  logic [8*N-1:0]   s_tdata;
  logic [N-1:0]     s_tvalid, s_tlast, s_tready;
  logic [7:0]       m_tdata;
  logic             m_tvalid, m_tready;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      timeout_cnt;

  logic [8*N-1:0]   b_s_tdata;
  logic [N-1:0]     b_s_tvalid, b_s_tlast, b_s_tready;
  logic [7:0]       b_m_tdata;
  logic             b_m_tvalid, b_m_tready;
  logic [1:0]       b_grant_id;
  logic             b_busy;
  logic [15:0]      b_timeout_cnt;

  uart_tx_arbiter #(.NUM_SRC(N), .IDLE_TIMEOUT(TO), .TAG_EN(1)) dut (
    .clk125(clk125), .reset_n(reset_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .grant_id(grant_id), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  uart_tx_arbiter #(.NUM_SRC(N), .IDLE_TIMEOUT(TO), .TAG_EN(0)) dut_b (
    .clk125(clk125), .reset_n(reset_n), .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid),
    .s_tlast(b_s_tlast), .s_tready(b_s_tready), .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid),
    .m_tready(b_m_tready), .grant_id(b_grant_id), .busy(b_busy), .timeout_cnt(b_timeout_cnt)
  );

  ent_t  srcq[N][$];
  ent_t  stage[N][$];
  exp_t  expq[$];
  int    stl[N];
  int    n_chk = 0, n_fail = 0;
  int    pops = 0, exp_pops = 0, cyc = 0, m_rr = 0;
  int    dly_min = 0, dly_max = 0;
  int    x_acc_cyc = 0, to_cyc = 0;
  logic  acc_q = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic stage_byte(input int src, input logic [7:0] d, input logic last, input int gap);
    stage[src].push_back('{d: d, last: last, gap: 8'(gap)});
  endtask

  // Reference: whole messages, served round-robin over sources that still hold one.
  task automatic load_model();
    ent_t mq[N][$];
    ent_t e;
    int   g;
    for (int i = 0; i < N; i++) mq[i] = stage[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
      if (g < 0) break;
      expq.push_back('{d: 8'h30 + 8'(g), g: 2'(g), lastb: 1'b0});
      expq.push_back('{d: 8'h3A, g: 2'(g), lastb: 1'b0});
      do begin
        e = mq[g].pop_front();
        expq.push_back('{d: e.d, g: 2'(g), lastb: e.last});
        exp_pops++;
      end while (!e.last);
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      srcq[i] = stage[i];
      stage[i].delete();
      stl[i] = 0;
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk125);
      if (expq.size() == 0 && !busy && srcs_empty()) break;
    end
    n_chk++;
    if (k == budget) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d cycles", nm, expq.size(), budget);
      expq.delete();
      for (int i = 0; i < N; i++) srcq[i].delete();
    end
    chk({nm, "_pops"}, pops, exp_pops);
  endtask

  // Source drivers: present queue heads, honouring per-byte stall gaps.
  initial begin
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    for (int i = 0; i < N; i++) stl[i] = 0;
    forever begin
      @(negedge clk125);
      for (int i = 0; i < N; i++) begin
        if (stl[i] > 0) begin
          stl[i]--;
          s_tvalid[i] = 1'b0;
        end else if (srcq[i].size() > 0) begin
          s_tvalid[i] = 1'b1;
          s_tdata[8*i +: 8] = srcq[i][0].d;
          s_tlast[i] = srcq[i][0].last;
        end else begin
          s_tvalid[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk125);
      cyc++;
      acc_q = m_tready && m_tvalid;
      if (reset_n) begin
        for (int i = 0; i < N; i++) begin
          if (s_tready[i] && s_tvalid[i]) begin
            pops++;
            if (srcq[i].size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL pop_empty: src %0d popped with nothing queued", i);
            end else begin
              void'(srcq[i].pop_front());
              stl[i] = (srcq[i].size() > 0) ? int'(srcq[i][0].gap) : 0;
            end
          end
        end
      end
    end
  end

  // UART model and scoreboard monitor: tready pulse after a random wait, compare on accept.
  initial begin
    int dcnt;
    logic [7:0] held_d;
    logic [1:0] held_g;
    exp_t e;
    dcnt = -1; held_d = '0; held_g = '0;
    m_tready = 1'b0;
    forever begin
      @(negedge clk125);
      if (m_tready) begin
        m_tready = 1'b0;
        dcnt = -1;
        if (reset_n) begin
          if (held_d == 8'h58) x_acc_cyc = cyc;
          if (expq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_unexpected: got byte %h src %0d with nothing expected", held_d, held_g);
          end else begin
            e = expq.pop_front();
            chk("sb_byte{data,src,busy}", {held_d, held_g, busy}, {e.d, e.g, ~e.lastb});
          end
        end
      end else if (!reset_n) begin
        dcnt = -1;
      end else if (m_tvalid) begin
        if (dcnt < 0) dcnt = int'($urandom_range(dly_max, dly_min));
        if (dcnt == 0) begin
          m_tready = 1'b1;
          held_d = m_tdata;
          held_g = grant_id;
        end else begin
          dcnt--;
        end
      end
    end
  end

  initial begin
    logic       prev_v;
    logic [7:0] prev_d;
    prev_v = 1'b0; prev_d = '0;
    forever begin
      @(negedge clk125);
      if (!reset_n) prev_v = 1'b0;
      else begin
        if (prev_v && !acc_q) chk("hold_stable", {m_tvalid, m_tdata}, {1'b1, prev_d});
        prev_v = m_tvalid;
        prev_d = m_tdata;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    b_s_tdata = '0; b_s_tvalid = '0; b_s_tlast = '0; b_m_tready = 1'b0;
    repeat (3) @(negedge clk125);
    chk("reset_a", {m_tvalid, m_tdata, s_tready, grant_id, busy, timeout_cnt}, 0);
    chk("reset_b", {b_m_tvalid, b_m_tdata, b_s_tready, b_grant_id, b_busy, b_timeout_cnt}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk125);

    dly_min = 0; dly_max = 3;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) stage_byte(i, 8'hA0 + 8'(i) + 8'(16 * r), 1'b1, 0);
      load_model();
      wait_drain("rr_round", 300);
    end

    for (int i = 0; i < N; i++) stage_byte(i, 8'h00, 1'b0, 0);
    for (int i = 0; i < N; i++) void'(stage[i].pop_back());
    stage_byte(1, 8'h41, 1'b0, 0);
    stage_byte(1, 8'h42, 1'b1, 2);
    load_model();
    wait_drain("src1_AB", 300);

    dly_min = 0; dly_max = 0;
    @(negedge clk125);
    srcq[2].push_back('{d: 8'h58, last: 1'b0, gap: 8'd0});
    srcq[2].push_back('{d: 8'h59, last: 1'b1, gap: 8'd60});
    srcq[3].push_back('{d: 8'h51, last: 1'b1, gap: 8'd0});
    for (int i = 0; i < N; i++) stl[i] = 0;
    expq.push_back('{d: 8'h32, g: 2'd2, lastb: 1'b0});
    expq.push_back('{d: 8'h3A, g: 2'd2, lastb: 1'b0});
    expq.push_back('{d: 8'h58, g: 2'd2, lastb: 1'b0});
    expq.push_back('{d: 8'h33, g: 2'd3, lastb: 1'b0});
    expq.push_back('{d: 8'h3A, g: 2'd3, lastb: 1'b0});
    expq.push_back('{d: 8'h51, g: 2'd3, lastb: 1'b1});
    expq.push_back('{d: 8'h32, g: 2'd2, lastb: 1'b0});
    expq.push_back('{d: 8'h3A, g: 2'd2, lastb: 1'b0});
    expq.push_back('{d: 8'h59, g: 2'd2, lastb: 1'b1});
    exp_pops += 3;
    m_rr = 3;
    begin
      int k;
      for (k = 0; k < 300; k++) begin
        @(negedge clk125);
        if (timeout_cnt != 0) break;
      end
      to_cyc = cyc;
      chk("timeout_seen", 32'(k < 300), 1);
    end
    chk("timeout_latency", to_cyc - x_acc_cyc, TO);
    chk("timeout_cnt_1", timeout_cnt, 1);
    wait_drain("timeout", 400);

    dly_min = 0; dly_max = 3;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) begin
        int nm;
        nm = int'($urandom_range(2, 0));
        for (int m = 0; m < nm; m++) begin
          int len;
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++)
            stage_byte(i, 8'($urandom), b == len - 1, (b == 0) ? 0 : int'($urandom_range(6, 0)));
        end
      end
      @(negedge clk125);
      load_model();
      wait_drain("random", 2000);
    end
    chk("no_extra_timeouts", timeout_cnt, 1);

    dly_min = 100; dly_max = 100;
    stage_byte(0, 8'h55, 1'b0, 0);
    stage_byte(0, 8'hAA, 1'b1, 0);
    @(negedge clk125);
    load_model();
    wait_drain("slow_uart", 1000);

    dly_min = 20; dly_max = 20;
    stage_byte(0, 8'h4D, 1'b0, 0);
    stage_byte(0, 8'h4E, 1'b1, 0);
    @(negedge clk125);
    load_model();
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(negedge clk125);
        if (pops == exp_pops - 1) break;
      end
      chk("first_byte_popped", 32'(k < 200), 1);
    end
    chk("send_before_reset", m_tvalid, 1);
    @(posedge clk125);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_mid_send", {m_tvalid, s_tready, busy, timeout_cnt}, 0);
    expq.delete();
    for (int i = 0; i < N; i++) begin srcq[i].delete(); stl[i] = 0; end
    pops = 0; exp_pops = 0; m_rr = 0;
    repeat (2) @(negedge clk125);
    reset_n = 1'b1;
    dly_min = 0; dly_max = 2;
    stage_byte(1, 8'h4B, 1'b1, 0);
    @(negedge clk125);
    load_model();
    wait_drain("after_reset", 300);

    @(negedge clk125);
    b_m_tready = 1'b1;
    @(negedge clk125);
    chk("b_spurious_tready", {b_s_tready, b_busy, b_m_tvalid, b_grant_id}, 0);
    b_m_tready = 1'b0;
    b_s_tdata = {8'h00, 8'h00, 8'h5A, 8'h00};
    b_s_tvalid = 4'b0010;
    b_s_tlast = 4'b0010;
    @(negedge clk125);
    chk("b_grant{busy,id,s_tready,m_tvalid}", {b_busy, b_grant_id, b_s_tready, b_m_tvalid},
        {1'b1, 2'd1, 4'b0010, 1'b0});
    @(negedge clk125);
    chk("b_pop{m_tvalid,m_tdata,s_tready,busy}", {b_m_tvalid, b_m_tdata, b_s_tready, b_busy},
        {1'b1, 8'h5A, 4'b0000, 1'b1});
    b_s_tvalid = '0;
    b_m_tready = 1'b1;
    @(negedge clk125);
    chk("b_done{busy,m_tvalid,id}", {b_busy, b_m_tvalid, b_grant_id}, {1'b0, 1'b0, 2'd1});
    b_m_tready = 1'b0;

    repeat (5) @(negedge clk125);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
